// File: rtl/soc_mem_pkg.sv
// Shared definitions for the RAM-port DMA initiator: FSM encoding, command
// modes and write-mask constants.
package soc_mem_pkg;

    // Operation sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } dma_state_e;

    // Command mode encoding, as presented on mode_i.
    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    // Write masks are active-high "do not write" bits. They are sized for the
    // widest supported word and sliced down by the user.
    localparam int                        MAX_WORD_WIDTH = 32;
    localparam logic [MAX_WORD_WIDTH-1:0] MASK_ALL_WRITE = '0;
    localparam logic [MAX_WORD_WIDTH-1:0] MASK_NONE      = '1;

endpackage

// File: rtl/soc_mem_dma_if.sv
// RAM port bus seen by an initiator (master) and by the RAM (slave).
// Signal names keep the initiator's point of view so they line up with the
// DMA's documented port list.
interface soc_mem_dma_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int WORD_WIDTH = 16
);

    logic                  grant_i;
    logic                  sel_o;
    logic                  read_o;
    logic                  write_o;
    logic [ADDR_WIDTH-1:0] addr_o;
    logic [WORD_WIDTH-1:0] mask_o;
    logic [WORD_WIDTH-1:0] data_o;
    logic [WORD_WIDTH-1:0] data_i;

    modport master (
        input  grant_i,
        input  data_i,
        output sel_o,
        output read_o,
        output write_o,
        output addr_o,
        output mask_o,
        output data_o
    );

    modport slave (
        input  grant_i,
        input  sel_o,
        input  read_o,
        input  write_o,
        input  addr_o,
        input  mask_o,
        input  data_o,
        output data_i
    );

endinterface

// File: rtl/soc_mem_dma.sv
// Block-copy / block-fill initiator for the on-chip RAM port.
// A copy alternates one read and one write per word; a fill issues writes
// back to back. Every bus cycle waits for grant_i, and a denied cycle freezes
// the whole block so the arbiter can stall it for any length of time.
module soc_mem_dma
    import soc_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int WORD_WIDTH = 16,   // 8, 16 or 32 to match the RAM instance
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic                  mode_i,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [WORD_WIDTH-1:0] fill_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    soc_mem_dma_if.master         bus
);

    localparam logic [WORD_WIDTH-1:0] MASK_WR   = MASK_ALL_WRITE[WORD_WIDTH-1:0];
    localparam logic [WORD_WIDTH-1:0] MASK_IDLE = MASK_NONE[WORD_WIDTH-1:0];

    dma_state_e            state_q;
    dma_state_e            state_d;

    logic                  mode_q;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [LEN_WIDTH-1:0]  remain_q;
    logic [WORD_WIDTH-1:0] pattern_q;
    logic [WORD_WIDTH-1:0] rd_data_q;
    logic                  first_wr_q;   // data_i holds the word read last cycle

    logic                  bus_req;
    logic                  accept;
    logic                  last_word;

    assign bus_req   = (state_q == ST_RD) || (state_q == ST_WR);
    assign accept    = bus_req && bus.grant_i;
    assign last_word = (remain_q == LEN_WIDTH'(1));
    assign busy_o    = (state_q != ST_IDLE);

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of process order.
            state_q <= state_d;
        end
    end

    // Next-state logic: a denied bus cycle simply keeps the current state.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch
        // is inferred.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        state_d = ST_DONE;
                    end else if (mode_i == MODE_FILL) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (accept) begin
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (accept) begin
                    if (last_word) begin
                        state_d = ST_DONE;
                    end else if (mode_q == MODE_COPY) begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus outputs decoded from state and pointers; idle outside RD/WR.
    always_comb begin
        bus.sel_o   = 1'b0;
        bus.read_o  = 1'b0;
        bus.write_o = 1'b0;
        bus.addr_o  = '0;
        bus.mask_o  = MASK_IDLE;
        bus.data_o  = '0;
        if (state_q == ST_RD) begin
            bus.sel_o  = 1'b1;
            bus.read_o = 1'b1;
            bus.addr_o = src_q;
        end else if (state_q == ST_WR) begin
            bus.sel_o   = 1'b1;
            bus.write_o = 1'b1;
            bus.addr_o  = dst_q;
            bus.mask_o  = MASK_WR;
            if (mode_q == MODE_FILL) begin
                bus.data_o = pattern_q;
            end else if (first_wr_q) begin
                // Read data arrives this cycle; forward it without waiting.
                bus.data_o = bus.data_i;
            end else begin
                // Stalled write: data_i may now belong to another master.
                bus.data_o = rd_data_q;
            end
        end
    end

    // Command latch, address pointers, word counter and read-data capture.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mode_q     <= MODE_COPY;
            src_q      <= '0;
            dst_q      <= '0;
            remain_q   <= '0;
            pattern_q  <= '0;
            rd_data_q  <= '0;
            first_wr_q <= 1'b0;
        end else begin
            first_wr_q <= (state_q == ST_RD) && accept;
            if (first_wr_q) begin
                rd_data_q <= bus.data_i;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        mode_q    <= mode_i;
                        src_q     <= src_addr_i;
                        dst_q     <= dst_addr_i;
                        remain_q  <= len_i;
                        pattern_q <= fill_data_i;
                    end
                end
                ST_RD: begin
                    if (accept) begin
                        src_q <= src_q + ADDR_WIDTH'(1);
                    end
                end
                ST_WR: begin
                    if (accept) begin
                        dst_q    <= dst_q + ADDR_WIDTH'(1);
                        remain_q <= remain_q - LEN_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Completion pulse, one cycle after the DONE state.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            done_o <= 1'b0;
        end else begin
            done_o <= (state_q == ST_DONE);
        end
    end

endmodule

// File: tb/tb_soc_mem_dma.sv
// Self-checking bench for soc_mem_dma: a RAM model answers the bus, a grant
// plan per cycle drives the arbiter, and a word-level reference model
// predicts memory contents, bus transaction order and done latency.
module tb_soc_mem_dma;
    import soc_mem_pkg::*;

    localparam int AW      = 9;
    localparam int WW      = 16;
    localparam int LW      = 10;
    localparam int DEPTH   = 1 << AW;
    localparam int GV_SIZE = 4096;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } acc_t;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          start_i;
    logic          mode_i;
    logic [AW-1:0] src_addr_i;
    logic [AW-1:0] dst_addr_i;
    logic [LW-1:0] len_i;
    logic [WW-1:0] fill_data_i;
    logic          busy_o;
    logic          done_o;

    soc_mem_dma_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

    soc_mem_dma #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .LEN_WIDTH(LW)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .start_i     (start_i),
        .mode_i      (mode_i),
        .src_addr_i  (src_addr_i),
        .dst_addr_i  (dst_addr_i),
        .len_i       (len_i),
        .fill_data_i (fill_data_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .bus         (bus)
    );

    always #5 clk_i = ~clk_i;

    int            n_cmp = 0;
    int            n_mis = 0;
    logic [WW-1:0] mem     [DEPTH];
    logic [WW-1:0] ref_mem [DEPTH];
    bit            gv      [GV_SIZE];
    logic          mem_init;
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [WW-1:0] pl_data;
    logic [AW-1:0] other_addr;
    acc_t          wr_log[$];
    logic [AW-1:0] rd_log[$];

    function automatic logic [WW-1:0] init_word(input int i);
        return WW'(i * 37 + 'h1234);
    endfunction

    // RAM: DMA access when granted, otherwise the other master reads.
    always @(posedge clk_i) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
            bus.data_i <= '0;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (bus.sel_o && bus.grant_i) begin
            if (bus.write_o)
                mem[bus.addr_o] <= (mem[bus.addr_o] & bus.mask_o) | (bus.data_o & ~bus.mask_o);
            if (bus.read_o)
                bus.data_i <= mem[bus.addr_o];
        end else if (!bus.grant_i) begin
            bus.data_i <= mem[other_addr];
        end
    end

    // Transaction monitor, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (bus.sel_o === 1'b1 && bus.grant_i === 1'b1) begin
            if (bus.write_o === 1'b1) wr_log.push_back(acc_t'{bus.addr_o, bus.data_o});
            if (bus.read_o === 1'b1) rd_log.push_back(bus.addr_o);
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_grant(input int stall_pct);
        for (int i = 0; i < GV_SIZE; i++) gv[i] = ($urandom_range(99) >= stall_pct);
        gv[0] = 1'b1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [WW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        ref_mem[a] = d;
        step();
        pl_en = 1'b0;
    endtask

    // One complete operation, checked against the word-level model.
    task automatic run_op(input string name, input logic mode, input logic [AW-1:0] src,
                          input logic [AW-1:0] dst, input logic [LW-1:0] len,
                          input logic [WW-1:0] pat, input int ign_at);
        acc_t          exp_wr[$];
        logic [AW-1:0] exp_rd[$];
        logic [AW-1:0] a, s;
        logic [WW-1:0] d;
        logic [43:0]   snap_cur, snap_prev;
        logic          stall_prev;
        int n_acc, t, exp_done, done_off, done_cnt, busy_cnt, wr_base, rd_base, bad, budget;

        for (int i = 0; i < int'(len); i++) begin
            a = dst + AW'(i);
            s = src + AW'(i);
            d = (mode == MODE_FILL) ? pat : ref_mem[s];
            if (mode == MODE_COPY) exp_rd.push_back(s);
            ref_mem[a] = d;
            exp_wr.push_back(acc_t'{a, d});
        end
        n_acc = (mode == MODE_FILL) ? int'(len) : 2 * int'(len);
        t = 0;
        while (n_acc > 0) begin
            t++;
            if (gv[t]) n_acc--;
        end
        exp_done = t + 2;
        budget   = exp_done + 10;
        wr_base  = wr_log.size();
        rd_base  = rd_log.size();

        step();
        start_i = 1'b1; mode_i = mode; src_addr_i = src; dst_addr_i = dst;
        len_i = len; fill_data_i = pat; bus.grant_i = gv[0];
        done_off = -1; done_cnt = 0; busy_cnt = 0; stall_prev = 1'b0; snap_prev = '0;
        for (int off = 1; off <= budget; off++) begin
            step();
            if (off == ign_at) begin
                start_i = 1'b1; mode_i = 1'($urandom); src_addr_i = AW'($urandom);
                dst_addr_i = AW'($urandom); len_i = LW'($urandom); fill_data_i = WW'($urandom);
            end else begin
                start_i = 1'b0;
            end
            bus.grant_i = gv[off];
            @(negedge clk_i);
            if (busy_o === 1'b1) busy_cnt++;
            if (done_o === 1'b1) begin
                done_cnt++;
                if (done_off < 0) done_off = off;
            end
            snap_cur = {bus.sel_o, bus.read_o, bus.write_o, bus.addr_o, bus.mask_o, bus.data_o};
            if (!bus.grant_i && bus.sel_o === 1'b1) begin
                if (stall_prev) begin
                    n_cmp++;
                    if (snap_cur !== snap_prev) begin
                        n_mis++;
                        $display("FAIL %s stall_hold: got %h want %h", name, snap_cur, snap_prev);
                    end
                end
                stall_prev = 1'b1;
                snap_prev  = snap_cur;
            end else begin
                stall_prev = 1'b0;
            end
            if (done_off >= 0 && off >= done_off + 2) break;
        end
        start_i = 1'b0;

        n_cmp++;
        if (done_off !== exp_done) begin
            n_mis++;
            $display("FAIL %s latency: got %0d want %0d", name, done_off, exp_done);
        end
        n_cmp++;
        if (done_cnt !== 1) begin
            n_mis++;
            $display("FAIL %s done_width: got %0d want 1", name, done_cnt);
        end
        n_cmp++;
        if (busy_cnt !== exp_done - 1) begin
            n_mis++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, exp_done - 1);
        end
        n_cmp++;
        if (wr_log.size() - wr_base !== exp_wr.size()) begin
            n_mis++;
            $display("FAIL %s write_count: got %0d want %0d", name, wr_log.size() - wr_base, exp_wr.size());
        end else begin
            bad = 0;
            for (int i = 0; i < exp_wr.size(); i++) begin
                if (wr_log[wr_base + i] !== exp_wr[i]) begin
                    if (bad == 0)
                        $display("FAIL %s write[%0d]: got %h want %h", name, i, wr_log[wr_base + i], exp_wr[i]);
                    bad++;
                end
            end
            n_cmp++;
            if (bad != 0) n_mis++;
        end
        if (mode == MODE_COPY) begin
            bad = (rd_log.size() - rd_base != exp_rd.size()) ? 1 : 0;
            for (int i = 0; bad == 0 && i < exp_rd.size(); i++)
                if (rd_log[rd_base + i] !== exp_rd[i]) bad++;
            n_cmp++;
            if (bad != 0) begin
                n_mis++;
                $display("FAIL %s read_seq: got %0d reads want %0d reads in order", name,
                         rd_log.size() - rd_base, exp_rd.size());
            end
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                if (bad == 0) $display("FAIL %s mem[%0h]: got %h want %h", name, i, mem[i], ref_mem[i]);
                bad++;
            end
        end
        n_cmp++;
        if (bad != 0) n_mis++;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({busy_o, done_o, bus.sel_o, bus.read_o, bus.write_o, bus.addr_o, bus.mask_o, bus.data_o}
            !== {5'b0, 9'h000, 16'hFFFF, 16'h0000}) begin
            n_mis++;
            $display("FAIL reset_values: got busy=%b done=%b sel=%b rd=%b wr=%b addr=%h mask=%h data=%h want zeros, mask ffff",
                     busy_o, done_o, bus.sel_o, bus.read_o, bus.write_o, bus.addr_o, bus.mask_o, bus.data_o);
        end
        repeat (3) @(posedge clk_i);
        #1;
        mem_init = 1'b0;
        rstn_i   = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if ({busy_o, done_o, bus.sel_o} !== 3'b000) begin
            n_mis++;
            $display("FAIL idle_after_reset: got %b want 000", {busy_o, done_o, bus.sel_o});
        end
    endtask

    task automatic test_fill_basic();
        set_grant(0);
        run_op("fill_basic", MODE_FILL, 9'h000, 9'h010, 10'd4, 16'hA5A5, -1);
    endtask

    task automatic test_copy_basic();
        set_grant(0);
        preload(9'h020, 16'h1111);
        preload(9'h021, 16'h2222);
        preload(9'h022, 16'h3333);
        run_op("copy_basic", MODE_COPY, 9'h020, 9'h100, 10'd3, 16'h0000, -1);
    endtask

    task automatic test_grant_stall();
        set_grant(0);
        gv[2] = 1'b0; gv[3] = 1'b0; gv[4] = 1'b0;
        other_addr = 9'h0AB;
        preload(9'h040, 16'hBEEF);
        preload(9'h041, 16'hCAFE);
        run_op("grant_stall", MODE_COPY, 9'h040, 9'h140, 10'd2, 16'h0000, -1);
    endtask

    task automatic test_len_zero();
        set_grant(0);
        run_op("len_zero", MODE_COPY, 9'h055, 9'h066, 10'd0, 16'h0000, -1);
    endtask

    task automatic test_wrap_ignored_start();
        set_grant(0);
        run_op("wrap_fill", MODE_FILL, 9'h000, 9'h1FE, 10'd4, 16'h5A3C, 2);
    endtask

    task automatic test_reset_mid_copy();
        int wr_base, waited;
        set_grant(0);
        for (int i = 0; i < 2; i++) ref_mem[9'h188 + i] = ref_mem[9'h080 + i];
        wr_base = wr_log.size();
        step();
        start_i = 1'b1; mode_i = MODE_COPY; src_addr_i = 9'h080; dst_addr_i = 9'h188;
        len_i = 10'd6; bus.grant_i = 1'b1;
        step();
        start_i = 1'b0;
        waited = 0;
        while (wr_log.size() - wr_base < 2 && waited < 20) begin
            @(negedge clk_i);
            waited++;
        end
        n_cmp++;
        if (wr_log.size() - wr_base < 2) begin
            n_mis++;
            $display("FAIL reset_mid_copy timeout: got %0d writes want 2", wr_log.size() - wr_base);
        end
        step();
        rstn_i = 1'b0;
        #1;
        n_cmp++;
        if ({busy_o, done_o, bus.sel_o, bus.read_o, bus.write_o, bus.addr_o, bus.mask_o, bus.data_o}
            !== {5'b0, 9'h000, 16'hFFFF, 16'h0000}) begin
            n_mis++;
            $display("FAIL reset_mid_copy async: got sel=%b rd=%b wr=%b busy=%b addr=%h mask=%h want idle reset values",
                     bus.sel_o, bus.read_o, bus.write_o, busy_o, bus.addr_o, bus.mask_o);
        end
        waited = 0;
        repeat (3) begin
            @(negedge clk_i);
            if (done_o !== 1'b0) waited++;
        end
        step();
        rstn_i = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            if (done_o !== 1'b0 || busy_o !== 1'b0) waited++;
        end
        n_cmp++;
        if (waited != 0) begin
            n_mis++;
            $display("FAIL reset_mid_copy no_done: got %0d active cycles want 0", waited);
        end
        run_op("fill_after_reset", MODE_FILL, 9'h000, 9'h0C0, 10'd5, 16'h0F0F, -1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            set_grant(30);
            other_addr = AW'($urandom);
            run_op($sformatf("random%0d", k), 1'($urandom), AW'($urandom), AW'($urandom),
                   LW'($urandom_range(24)), WW'($urandom), 1);
        end
    endtask

    task automatic test_max_len();
        set_grant(0);
        run_op("max_len_fill", MODE_FILL, 9'h000, AW'($urandom), 10'h3FF, WW'($urandom), 7);
    endtask

    initial begin
        rstn_i = 1'b0; mem_init = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        start_i = 1'b0; mode_i = 1'b0; src_addr_i = '0; dst_addr_i = '0; len_i = '0;
        fill_data_i = '0; bus.grant_i = 1'b1; other_addr = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_fill_basic();
        test_copy_basic();
        test_grant_stall();
        test_len_zero();
        test_wrap_ignored_start();
        test_reset_mid_copy();
        test_random();
        test_max_len();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/soc_mem_dma.md
Name: soc_mem_dma

Overview:
Bus initiator for the on-chip RAM port: drives the sel/read/write/addr/mask/data interface that the RAM blocks respond to. It executes block-copy (RAM to RAM) and block-fill operations, then returns a done pulse. It sits beside the CPU on the RAM port behind a simple grant arbiter, and offloads memory initialisation and buffer moves.

Parameters:
ADDR_WIDTH, 9, word address width of the RAM port; addresses wrap modulo 2^ADDR_WIDTH.
WORD_WIDTH, 16, data width; must be 8, 16 or 32, matching the RAM instance.
LEN_WIDTH, 10, width of the transfer length, in words.

Ports:
clk_i  in  1  system clock; all logic on its rising edge.
rstn_i  in  1  reset, asynchronous, active-low.
start_i  in  1  command strobe; sampled only in IDLE.
mode_i  in  1  0 = copy, 1 = fill; sampled with start_i.
src_addr_i  in  ADDR_WIDTH  copy source start address.
dst_addr_i  in  ADDR_WIDTH  destination start address.
len_i  in  LEN_WIDTH  number of words to transfer.
fill_data_i  in  WORD_WIDTH  fill pattern; sampled with start_i.
busy_o  out  1  high from the cycle after an accepted start until done.
done_o  out  1  one-cycle pulse when the operation completes.
grant_i  in  1  arbiter grant; a bus cycle is accepted only when grant_i=1.
sel_o  out  1  RAM select.
read_o  out  1  read request.
write_o  out  1  write request.
addr_o  out  ADDR_WIDTH  RAM word address.
mask_o  out  WORD_WIDTH  write mask; 1 = bit not written.
data_o  out  WORD_WIDTH  write data.
data_i  in  WORD_WIDTH  RAM read data, valid the cycle after an accepted read.

Behaviour:
- Interface facts: one clock; reset asynchronous, active-low on rstn_i.
- Reset values: busy_o, done_o, sel_o, read_o and write_o = 0; addr_o and data_o = 0; mask_o all ones. Reset mid-operation aborts immediately with no done pulse, and the FSM returns to IDLE.
- Accepted bus cycle: sel_o & grant_i. While grant_i=0, all bus outputs and the internal state hold. Stalls of any length are legal.
- States:
  - IDLE: on start_i, latch all command inputs. If len_i=0, go to DONE. Otherwise go to RD (copy) or WR (fill).
  - RD: sel_o=1, read_o=1, addr_o=src pointer. When accepted: increment src pointer and go to WR.
  - WR: sel_o=1, write_o=1, mask_o=0, addr_o=dst pointer.
    - Fill: data_o = latched pattern.
    - Copy: data_o = the word returned by the preceding read. In the first WR cycle that word is data_i; it is also registered so it stays correct across stalls, when the arbiter's other master may change data_i.
    - When accepted: increment dst pointer and decrement the remaining count. If the count reaches 0, go to DONE. Otherwise go to RD (copy) or stay in WR (fill).
  - DONE: done_o=1 for one cycle, bus idle, then IDLE.
- Latency with grant_i held high: fill takes len+2 cycles from the start cycle to the done pulse; copy takes 2*len+2.
- Outside RD/WR: sel_o, read_o and write_o = 0, and mask_o all ones.
- Pointers wrap modulo 2^ADDR_WIDTH.
- Copy always runs in ascending addresses. Overlapping regions with dst > src replicate data; the block does not detect or correct this.
- start_i while busy is ignored.
- len_i = 2^LEN_WIDTH-1 is legal and is the maximum.

Decomposition:
- Shared package (soc_mem_pkg):
  - state encodings IDLE/RD/WR/DONE
  - MODE_COPY=0, MODE_FILL=1
  - MASK_ALL_WRITE (zeros) and MASK_NONE (ones) constants
- Single module. The bus-output register stage is small enough to stay inline, so no sub-module.

Test Plan:
- Fill: dst=0x010, len=4, pattern=0xA5A5, grant_i=1 -> writes at 0x010..0x013 on consecutive cycles; done_o at start+6; readback all 0xA5A5; 0x014 unchanged.
- Copy: preload 0x020..0x022 = 0x1111/0x2222/0x3333; copy src=0x020, dst=0x100, len=3 -> alternating read/write; done at start+8; 0x100..0x102 match.
- Grant stall: copy len=2; deassert grant_i for 3 cycles in the first WR, with another master reading a different address -> written data is still the source word; outputs hold during the stall; done is delayed by 3 cycles.
- len=0 -> no sel_o; done_o pulses at start+2; busy_o high for exactly 1 cycle.
- Wrap plus ignored start: fill dst=0x1FE, len=4 -> writes 0x1FE, 0x1FF, 0x000, 0x001. A start_i mid-operation has no effect.
- Reset mid-copy: drop rstn_i after 2 words -> all outputs at reset values asynchronously; no done_o; a new fill after reset completes normally.
